dest_scheduler: RTL and testbench

- Parametrised successor to the five-floor destination setter: N-floor elevator request scheduler with latched car calls and separate up and down hall calls.
- Selects the next stop with a registered LOOK (directional sweep) policy.
- Sits between the button/debounce front end and the car motion FSM: consumes the motion state and current floor, and produces the destination floor plus per-button indicator lamps.
- Replaces the internal pushbutton instances with its own request latches and a direction-aware clear.

---
 rtl/elev_pkg.sv | 18 +
 rtl/dest_scheduler_req_latch.sv | 19 +
 rtl/dest_scheduler.sv | 142 ++++++++++++++
 tb/tb_dest_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared encodings and helpers for the elevator request scheduler.
package elev_pkg;

    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DOOR    = 2'd1,
        ST_MOVE_UP = 2'd2,
        ST_MOVE_DN = 2'd3
    } state_t;

    // Floors are numbered from 1; lamp vectors are indexed from 0.
    function automatic int floor_idx(input int loc);
        return loc - 1;
    endfunction

endpackage

// File: rtl/dest_scheduler_req_latch.sv
// One request lamp: set by a press pulse, held until cleared; clear beats set.
module req_latch (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (clr)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
    end

endmodule

// File: rtl/dest_scheduler.sv
// N-floor LOOK scheduler: latches car/hall calls, clears them at stops and
// registers the next destination floor and sweep direction.
module dest_scheduler
    import elev_pkg::*;
#(
    parameter int N_FLOORS = 5,
    parameter int FLOOR_W  = $clog2(N_FLOORS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] btn_car,
    input  logic [N_FLOORS-1:0] btn_up,
    input  logic [N_FLOORS-1:0] btn_dn,
    input  logic [1:0]          state,
    input  logic [FLOOR_W-1:0]  location,
    output logic [FLOOR_W-1:0]  dest,
    output logic                dest_valid,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] lamp_car,
    output logic [N_FLOORS-1:0] lamp_up,
    output logic [N_FLOORS-1:0] lamp_dn
);

    // No up call from the top floor, no down call from floor 1.
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    state_t              st;
    int                  loc_i;
    logic                loc_ok;
    logic                stopped;
    logic [N_FLOORS-1:0] car_q, up_q, dn_q;
    logic [N_FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic [N_FLOORS-1:0] all_req, cu_req, cd_req;
    logic                any_above, any_below, ahead, behind;
    int                  up_near, dn_high, dn_near, up_low;
    int                  s1, s2, s3, s4, pick;
    logic [FLOOR_W-1:0]  dest_p0;
    logic                dest_valid_p0;
    logic                dir_up_p0;

    assign st      = state_t'(state);
    assign loc_i   = int'(location);
    assign loc_ok  = (loc_i >= 1) && (loc_i <= N_FLOORS);
    assign stopped = (st == ST_IDLE) || (st == ST_DOOR);

    assign lamp_car = car_q;
    assign lamp_up  = up_q & UP_MASK;
    assign lamp_dn  = dn_q & DN_MASK;
    assign all_req  = lamp_car | lamp_up | lamp_dn;
    assign cu_req   = lamp_car | lamp_up;
    assign cd_req   = lamp_car | lamp_dn;

    for (genvar g = 0; g < N_FLOORS; g++) begin : g_floor
        req_latch u_car (.clk(clk), .reset(reset), .set(btn_car[g]),
                         .clr(clr_car[g]), .q(car_q[g]));
        req_latch u_up  (.clk(clk), .reset(reset), .set(btn_up[g] & UP_MASK[g]),
                         .clr(clr_up[g]), .q(up_q[g]));
        req_latch u_dn  (.clk(clk), .reset(reset), .set(btn_dn[g] & DN_MASK[g]),
                         .clr(clr_dn[g]), .q(dn_q[g]));
    end

    // Stage p0: priority scans relative to the current location.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        up_near   = 0;
        dn_high   = 0;
        dn_near   = 0;
        up_low    = 0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if ((i + 1 > loc_i) && cu_req[i])  up_near = i + 1;
            if ((i + 1 < loc_i) && lamp_up[i]) up_low  = i + 1;
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if ((i + 1 > loc_i) && lamp_dn[i]) dn_high = i + 1;
            if ((i + 1 < loc_i) && cd_req[i])  dn_near = i + 1;
            if ((i + 1 > loc_i) && all_req[i]) any_above = 1'b1;
            if ((i + 1 < loc_i) && all_req[i]) any_below = 1'b1;
        end
    end

    assign ahead  = dir_up ? any_above : any_below;
    assign behind = dir_up ? any_below : any_above;

    always_comb begin
        clr_car = '0;
        clr_up  = '0;
        clr_dn  = '0;
        if (stopped && loc_ok) begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (i == floor_idx(loc_i)) begin
                    clr_car[i] = 1'b1;
                    clr_up[i]  = dir_up || !ahead;
                    clr_dn[i]  = !dir_up || !ahead;
                end
            end
        end
    end

    // Sweep in the current direction, then turn around, then the other way.
    always_comb begin
        s1   = dir_up ? up_near : dn_near;
        s2   = dir_up ? dn_high : up_low;
        s3   = dir_up ? dn_near : up_near;
        s4   = dir_up ? up_low  : dn_high;
        pick = loc_i;
        if (s1 != 0)      pick = s1;
        else if (s2 != 0) pick = s2;
        else if (s3 != 0) pick = s3;
        else if (s4 != 0) pick = s4;
    end

    always_comb begin
        dest_p0       = dest;
        dest_valid_p0 = dest_valid;
        dir_up_p0     = dir_up;
        if (loc_ok) begin
            dest_p0       = FLOOR_W'(pick);
            dest_valid_p0 = |all_req;
            case (st)
                ST_MOVE_UP: dir_up_p0 = 1'b1;
                ST_MOVE_DN: dir_up_p0 = 1'b0;
                default:    if (!ahead && behind) dir_up_p0 = !dir_up;
            endcase
        end
    end

    // Stage p1: registered destination and direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest       <= FLOOR_W'(1);
            dest_valid <= 1'b0;
            dir_up     <= 1'b1;
        end else begin
            dest       <= dest_p0;
            dest_valid <= dest_valid_p0;
            dir_up     <= dir_up_p0;
        end
    end

endmodule

// File: tb/tb_dest_scheduler.sv
// Randomized and directed bench for dest_scheduler with a floor-walking reference model.
module tb_dest_scheduler;

    localparam int NF = 5;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] btn_car, btn_up, btn_dn;
    logic [1:0]    state;
    logic [FW-1:0] location;
    logic [FW-1:0] dest;
    logic          dest_valid, dir_up;
    logic [NF-1:0] lamp_car, lamp_up, lamp_dn;

    int n_vec = 0;
    int n_mis = 0;

    bit [NF-1:0] m_car, m_up, m_dn;
    bit          m_dir;
    int          m_dest;
    bit          m_vld;

    dest_scheduler #(.N_FLOORS(NF), .FLOOR_W(FW)) dut (
        .clk(clk), .reset(reset),
        .btn_car(btn_car), .btn_up(btn_up), .btn_dn(btn_dn),
        .state(state), .location(location),
        .dest(dest), .dest_valid(dest_valid), .dir_up(dir_up),
        .lamp_car(lamp_car), .lamp_up(lamp_up), .lamp_dn(lamp_dn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit has(input bit [NF-1:0] m, input int f);
        bit [NF-1:0] s;
        s = m >> (f - 1);
        return s[0];
    endfunction

    // Closest requested floor walking away from loc in the given direction.
    function automatic int nearest(input int loc, input bit up, input bit [NF-1:0] m);
        for (int d = 1; d < NF; d++) begin
            int f;
            f = up ? loc + d : loc - d;
            if (f >= 1 && f <= NF && has(m, f)) return f;
        end
        return 0;
    endfunction

    function automatic int farthest(input int loc, input bit up, input bit [NF-1:0] m);
        for (int d = NF - 1; d >= 1; d--) begin
            int f;
            f = up ? loc + d : loc - d;
            if (f >= 1 && f <= NF && has(m, f)) return f;
        end
        return 0;
    endfunction

    function automatic int target(input int loc, input bit dirup);
        int c[4];
        c[0] = dirup ? nearest(loc, 1, m_car | m_up)  : nearest(loc, 0, m_car | m_dn);
        c[1] = dirup ? farthest(loc, 1, m_dn)         : farthest(loc, 0, m_up);
        c[2] = dirup ? nearest(loc, 0, m_car | m_dn)  : nearest(loc, 1, m_car | m_up);
        c[3] = dirup ? farthest(loc, 0, m_up)         : farthest(loc, 1, m_dn);
        foreach (c[k]) if (c[k] != 0) return c[k];
        return loc;
    endfunction

    task automatic step();
        bit [NF-1:0] nc, nu, nd, oh, all;
        bit          ahead, behind;
        int          loc, tgt;
        @(posedge clk);
        loc = int'(location);
        if (reset) begin
            m_car = '0; m_up = '0; m_dn = '0;
            m_dir = 1'b1; m_dest = 1; m_vld = 1'b0;
        end else begin
            nc = m_car | btn_car;
            nu = m_up | (btn_up & 5'b01111);
            nd = m_dn | (btn_dn & 5'b11110);
            if (loc >= 1 && loc <= NF) begin
                all    = m_car | m_up | m_dn;
                ahead  = nearest(loc, m_dir, all) != 0;
                behind = nearest(loc, !m_dir, all) != 0;
                if (state == 2'd0 || state == 2'd1) begin
                    oh = 5'b00001 << (loc - 1);
                    nc &= ~oh;
                    if (m_dir || !ahead)  nu &= ~oh;
                    if (!m_dir || !ahead) nd &= ~oh;
                end
                tgt    = target(loc, m_dir);
                m_dest = tgt;
                m_vld  = |all;
                if (state == 2'd2)               m_dir = 1'b1;
                else if (state == 2'd3)          m_dir = 1'b0;
                else if (!ahead && behind)       m_dir = !m_dir;
            end
            m_car = nc; m_up = nu; m_dn = nd;
        end
        #1;
        chk("dest",       16'(dest),       16'(m_dest));
        chk("dest_valid", 16'(dest_valid), 16'(m_vld));
        chk("dir_up",     16'(dir_up),     16'(m_dir));
        chk("lamp_car",   16'(lamp_car),   16'(m_car));
        chk("lamp_up",    16'(lamp_up),    16'(m_up));
        chk("lamp_dn",    16'(lamp_dn),    16'(m_dn));
        btn_car = '0; btn_up = '0; btn_dn = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btn_car = '0; btn_up = '0; btn_dn = '0;
        state = 2'd0; location = 3'd1;

        // Reset state
        do_reset();
        chk("rst_dest", 16'(dest), 16'd1);
        chk("rst_vld",  16'(dest_valid), 16'd0);
        chk("rst_dir",  16'(dir_up), 16'd1);
        chk("rst_lamps", 16'({lamp_car, lamp_up, lamp_dn}), 16'd0);
        step();
        chk("idle_dest", 16'(dest), 16'd1);
        chk("idle_vld",  16'(dest_valid), 16'd0);

        // Car call to 4, then hall up call at 2 retargets
        btn_car[3] = 1'b1; step();
        chk("car4_lamp", 16'(lamp_car), 16'h08);
        btn_up[1] = 1'b1; step();
        chk("car4_dest", 16'(dest), 16'd4);
        chk("car4_vld",  16'(dest_valid), 16'd1);
        step();
        chk("up2_dest", 16'(dest), 16'd2);
        chk("up2_lamp", 16'(lamp_up), 16'h02);

        // Turnaround to highest down call, then clear on arrival
        do_reset();
        state = 2'd2; location = 3'd2;
        btn_dn[4] = 1'b1; step();
        step();
        chk("turn_dest", 16'(dest), 16'd5);
        state = 2'd1; location = 3'd5;
        step();
        chk("turn_clr", 16'(lamp_dn), 16'd0);
        step();
        chk("turn_vld", 16'(dest_valid), 16'd0);
        chk("turn_dest_loc", 16'(dest), 16'd5);

        // Only request behind: direction flips
        do_reset();
        state = 2'd0; location = 3'd3;
        btn_car[0] = 1'b1; step();
        step();
        chk("flip_dir",  16'(dir_up), 16'd0);
        chk("flip_dest", 16'(dest), 16'd1);

        // Press at the floor being served is dropped; latches while moving
        do_reset();
        state = 2'd1; location = 3'd3;
        btn_up[2] = 1'b1; step();
        chk("drop_up", 16'(lamp_up), 16'd0);
        state = 2'd2;
        btn_up[2] = 1'b1; step();
        chk("move_up_latch", 16'(lamp_up), 16'h04);

        // Edge bits never light
        btn_up[4] = 1'b1; btn_dn[0] = 1'b1; step();
        chk("edge_bits", 16'({lamp_up[4], lamp_dn[0]}), 16'd0);

        // Mid-operation reset
        do_reset();
        state = 2'd0; location = 3'd1;
        btn_car[3] = 1'b1; btn_dn[2] = 1'b1; step();
        step();
        chk("pre_rst_dest", 16'(dest), 16'd4);
        do_reset();
        chk("mid_rst_dest", 16'(dest), 16'd1);
        chk("mid_rst_vld",  16'(dest_valid), 16'd0);
        chk("mid_rst_lamps", 16'({lamp_car, lamp_up, lamp_dn}), 16'd0);

        // Randomized traffic, occasional invalid location and reset
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            state    = 2'($urandom_range(0, 3));
            location = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                   : 3'($urandom_range(1, NF));
            btn_car  = 5'($urandom & $urandom & $urandom);
            btn_up   = 5'($urandom & $urandom & $urandom);
            btn_dn   = 5'($urandom & $urandom & $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
